// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and control unit for the 5-stage IF/ID/EX/MEM/WB core.
// Produces EX operand forwarding selects, load-use stalls, branch/jump redirect
// flushes and data-memory wait stalls. A watchdog moves to a sticky error state
// if memory never responds. Saturating stall and flush counters are also kept.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_idRs1/2, i_idUseRs1/2         ID-stage sources and their use flags
//   i_exRs1/2, i_exRd               EX-stage sources and destination
//   i_exRegWR, i_exIsLoad           EX writes rd / EX is a load
//   i_exDoBranch, i_exBranchTaken,
//   i_exDoJump                      EX branch/jump resolution
//   i_memRd, i_memRegWR             MEM destination and write enable
//   i_wbRd, i_wbRegWR               WB destination and write enable
//   i_memReq, i_memReady            data-memory request / completion
//   o_stallF/D/E/M                  hold the stage registers (combinational)
//   o_flushD/E/W                    insert a bubble into the stage register (combinational)
//   o_redirect                      PC takes the branch/jump target (combinational)
//   o_fwdA, o_fwdB                  EX operand source: 00 regfile, 01 WB, 10 MEM
//   o_memErr                        sticky memory timeout flag (registered)
//   o_stallCount, o_flushCount      saturating performance counters (registered)
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned WAIT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_idRs1,
  input  logic [4:0]       i_idRs2,
  input  logic             i_idUseRs1,
  input  logic             i_idUseRs2,
  input  logic [4:0]       i_exRs1,
  input  logic [4:0]       i_exRs2,
  input  logic [4:0]       i_exRd,
  input  logic             i_exRegWR,
  input  logic             i_exIsLoad,
  input  logic             i_exDoBranch,
  input  logic             i_exBranchTaken,
  input  logic             i_exDoJump,
  input  logic [4:0]       i_memRd,
  input  logic             i_memRegWR,
  input  logic [4:0]       i_wbRd,
  input  logic             i_wbRegWR,
  input  logic             i_memReq,
  input  logic             i_memReady,
  output logic             o_stallF,
  output logic             o_stallD,
  output logic             o_stallE,
  output logic             o_stallM,
  output logic             o_flushD,
  output logic             o_flushE,
  output logic             o_flushW,
  output logic             o_redirect,
  output logic [1:0]       o_fwdA,
  output logic [1:0]       o_fwdB,
  output logic             o_memErr,
  output logic [CNT_W-1:0] o_stallCount,
  output logic [CNT_W-1:0] o_flushCount
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [WAIT_W-1:0] w_waitCnt_nxt;
  logic              r_memErr;
  logic [CNT_W-1:0]  r_stallCount;
  logic [CNT_W-1:0]  r_flushCount;

  logic w_memStall;
  logic w_redirect;
  logic w_loadUse;

  // Hazard conditions; x0 never produces a hazard
  assign w_memStall = (r_state != ST_ERROR) && i_memReq && !i_memReady;
  assign w_redirect = i_exDoJump || (i_exDoBranch && i_exBranchTaken);
  assign w_loadUse  = i_exIsLoad && i_exRegWR && (i_exRd != 5'd0) &&
                      ((i_idUseRs1 && (i_idRs1 == i_exRd)) ||
                       (i_idUseRs2 && (i_idRs2 == i_exRd)));

  // Operand forwarding, MEM result is younger so it wins over WB
  always_comb begin : fwd_sel
    o_fwdA = 2'b00;
    o_fwdB = 2'b00;
    if (rst_n) begin
      if (i_memRegWR && (i_memRd != 5'd0) && (i_memRd == i_exRs1))
        o_fwdA = 2'b10;
      else if (i_wbRegWR && (i_wbRd != 5'd0) && (i_wbRd == i_exRs1))
        o_fwdA = 2'b01;
      if (i_memRegWR && (i_memRd != 5'd0) && (i_memRd == i_exRs2))
        o_fwdB = 2'b10;
      else if (i_wbRegWR && (i_wbRd != 5'd0) && (i_wbRd == i_exRs2))
        o_fwdB = 2'b01;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin : fsm_reg
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_waitCnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_waitCnt <= w_waitCnt_nxt;
    end
  end

  // Next state: count wait cycles, trip the watchdog when the limit is reached
  always_comb begin : fsm_next
    w_state_nxt   = r_state;
    w_waitCnt_nxt = r_waitCnt;
    case (r_state)
      ST_RUN: begin
        if (w_memStall) begin
          w_state_nxt   = ST_MEM_WAIT;
          w_waitCnt_nxt = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (i_memReady) begin
          w_state_nxt   = ST_RUN;
          w_waitCnt_nxt = '0;
        end else if ((MEM_TIMEOUT != 0) && (r_waitCnt == WAIT_W'(MEM_TIMEOUT))) begin
          w_state_nxt = ST_ERROR;
        end else begin
          w_waitCnt_nxt = r_waitCnt + WAIT_W'(1);
        end
      end
      ST_ERROR: begin
        w_state_nxt = ST_ERROR;
      end
      default: begin
        w_state_nxt   = ST_RUN;
        w_waitCnt_nxt = '0;
      end
    endcase
  end

  // Pipeline control outputs in priority order
  always_comb begin : ctl_out
    o_stallF   = 1'b0;
    o_stallD   = 1'b0;
    o_stallE   = 1'b0;
    o_stallM   = 1'b0;
    o_flushD   = 1'b0;
    o_flushE   = 1'b0;
    o_flushW   = 1'b0;
    o_redirect = 1'b0;
    if (!rst_n) begin
      o_flushD = 1'b1;
      o_flushE = 1'b1;
      o_flushW = 1'b1;
    end else if ((r_state == ST_ERROR) || w_memStall) begin
      // A branch held in EX waits here and resolves on the memReady cycle
      o_stallF = 1'b1;
      o_stallD = 1'b1;
      o_stallE = 1'b1;
      o_stallM = 1'b1;
      o_flushW = 1'b1;
    end else if (w_redirect) begin
      // The ID instruction is squashed, so a load-use hazard is moot
      o_redirect = 1'b1;
      o_flushD   = 1'b1;
      o_flushE   = 1'b1;
    end else if (w_loadUse) begin
      o_stallF = 1'b1;
      o_stallD = 1'b1;
      o_flushE = 1'b1;
    end
  end

  // Sticky error flag and saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin : perf_reg
    if (!rst_n) begin
      r_memErr     <= 1'b0;
      r_stallCount <= '0;
      r_flushCount <= '0;
    end else begin
      if (w_state_nxt == ST_ERROR)
        r_memErr <= 1'b1;
      if (o_stallF && (r_state != ST_ERROR) && (r_stallCount != CNT_MAX))
        r_stallCount <= r_stallCount + CNT_W'(1);
      if (o_redirect && (r_flushCount != CNT_MAX))
        r_flushCount <= r_flushCount + CNT_W'(1);
    end
  end

  assign o_memErr     = r_memErr;
  assign o_stallCount = r_stallCount;
  assign o_flushCount = r_flushCount;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (MEM_TIMEOUT=4, narrow counters so
// saturation is reachable). Inputs change 1 time unit after the rising edge;
// outputs are sampled 1 unit later.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  // Control vector order: stallF stallD stallE stallM flushD flushE flushW redirect
  localparam logic [7:0] C_IDLE  = 8'b0000_0000;
  localparam logic [7:0] C_RST   = 8'b0000_1110;
  localparam logic [7:0] C_LU    = 8'b1100_0100;
  localparam logic [7:0] C_RD    = 8'b0000_1101;
  localparam logic [7:0] C_MS    = 8'b1111_0010;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] idRs1, idRs2, exRs1, exRs2, exRd, memRd, wbRd;
  logic idUseRs1, idUseRs2, exRegWR, exIsLoad, exDoBranch, exBranchTaken, exDoJump;
  logic memRegWR, wbRegWR, memReq, memReady;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushW, redirect;
  logic [1:0] fwdA, fwdB;
  logic memErr;
  logic [CNT_W-1:0] stallCount, flushCount;
  logic [7:0] w_ctl;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign w_ctl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW, redirect};

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W), .WAIT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_idRs1(idRs1), .i_idRs2(idRs2), .i_idUseRs1(idUseRs1), .i_idUseRs2(idUseRs2),
    .i_exRs1(exRs1), .i_exRs2(exRs2), .i_exRd(exRd), .i_exRegWR(exRegWR),
    .i_exIsLoad(exIsLoad), .i_exDoBranch(exDoBranch), .i_exBranchTaken(exBranchTaken),
    .i_exDoJump(exDoJump), .i_memRd(memRd), .i_memRegWR(memRegWR),
    .i_wbRd(wbRd), .i_wbRegWR(wbRegWR), .i_memReq(memReq), .i_memReady(memReady),
    .o_stallF(stallF), .o_stallD(stallD), .o_stallE(stallE), .o_stallM(stallM),
    .o_flushD(flushD), .o_flushE(flushE), .o_flushW(flushW), .o_redirect(redirect),
    .o_fwdA(fwdA), .o_fwdB(fwdB), .o_memErr(memErr),
    .o_stallCount(stallCount), .o_flushCount(flushCount)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    idRs1 = '0; idRs2 = '0; idUseRs1 = 1'b0; idUseRs2 = 1'b0;
    exRs1 = '0; exRs2 = '0; exRd = '0; exRegWR = 1'b0; exIsLoad = 1'b0;
    exDoBranch = 1'b0; exBranchTaken = 1'b0; exDoJump = 1'b0;
    memRd = '0; memRegWR = 1'b0; wbRd = '0; wbRegWR = 1'b0;
    memReq = 1'b0; memReady = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_load_use();
    exIsLoad = 1'b1; exRegWR = 1'b1; exRd = 5'd3;
    idUseRs2 = 1'b1; idRs2 = 5'd3;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #2;
    chk("rst_ctl", 32'(w_ctl), 32'(C_RST));
    chk("rst_fwd", 32'({fwdA, fwdB}), 32'(0));
    chk("rst_memErr", 32'(memErr), 32'(0));
    chk("rst_counts", 32'({stallCount, flushCount}), 32'(0));
    step();
    rst_n = 1'b1;
    #1;
    chk("idle_ctl", 32'(w_ctl), 32'(C_IDLE));

    // Forwarding: MEM beats WB, x0 never forwards
    memRegWR = 1'b1; memRd = 5'd5; wbRegWR = 1'b1; wbRd = 5'd5; exRs1 = 5'd5; exRs2 = 5'd0;
    #1;
    chk("fwdA_mem", 32'(fwdA), 32'(2'b10));
    chk("fwdB_x0", 32'(fwdB), 32'(2'b00));
    memRegWR = 1'b0;
    #1;
    chk("fwdA_wb", 32'(fwdA), 32'(2'b01));
    memRegWR = 1'b1; wbRd = 5'd7; exRs2 = 5'd7;
    #1;
    chk("fwdA_mem2", 32'(fwdA), 32'(2'b10));
    chk("fwdB_wb", 32'(fwdB), 32'(2'b01));
    memRd = 5'd0; wbRd = 5'd0; exRs1 = 5'd0; exRs2 = 5'd0;
    #1;
    chk("fwd_zero_reg", 32'({fwdA, fwdB}), 32'(0));
    clear_inputs();

    // Load-use for one cycle, then the EX bubble clears it
    set_load_use();
    #1;
    chk("lu_ctl", 32'(w_ctl), 32'(C_LU));
    step();
    exIsLoad = 1'b0; exRegWR = 1'b0; exRd = 5'd0;
    #1;
    chk("lu_bubble", 32'(w_ctl), 32'(C_IDLE));
    chk("lu_stallCount", 32'(stallCount), 32'(1));
    set_load_use(); exRd = 5'd0; idRs2 = 5'd0;
    #1;
    chk("lu_x0", 32'(w_ctl), 32'(C_IDLE));
    set_load_use(); idUseRs2 = 1'b0;
    #1;
    chk("lu_unused_src", 32'(w_ctl), 32'(C_IDLE));
    clear_inputs();

    // Taken branch beats load-use; not-taken leaves the load-use stall
    set_load_use(); exDoBranch = 1'b1; exBranchTaken = 1'b1;
    #1;
    chk("br_ctl", 32'(w_ctl), 32'(C_RD));
    step();
    clear_inputs();
    #1;
    chk("br_flushCount", 32'(flushCount), 32'(1));
    chk("br_stallCount", 32'(stallCount), 32'(1));
    set_load_use(); exDoBranch = 1'b1; exBranchTaken = 1'b0;
    #1;
    chk("br_nt_ctl", 32'(w_ctl), 32'(C_LU));
    step();
    clear_inputs();
    #1;
    chk("br_nt_counts", 32'({stallCount, flushCount}), 32'({4'd2, 4'd1}));

    // Memory wait: three stalled cycles then ready
    do_reset();
    memReq = 1'b1; memReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_ctl%0d", i), 32'(w_ctl), 32'(C_MS));
      step();
    end
    memReady = 1'b1;
    #1;
    chk("mw_ready_ctl", 32'(w_ctl), 32'(C_IDLE));
    step();
    clear_inputs();
    #1;
    chk("mw_stallCount", 32'(stallCount), 32'(3));
    chk("mw_memErr", 32'(memErr), 32'(0));
    // Back in RUN: a fresh request starts a new full wait (no early timeout)
    memReq = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("mw_rerun_memErr", 32'(memErr), 32'(1));
    clear_inputs();

    // Timeout: ERROR entered after five stalled cycles
    do_reset();
    memReq = 1'b1; memReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("to_ctl%0d", i), 32'(w_ctl), 32'(C_MS));
      chk($sformatf("to_noerr%0d", i), 32'(memErr), 32'(0));
      step();
    end
    chk("to_memErr", 32'(memErr), 32'(1));
    chk("to_stallCount", 32'(stallCount), 32'(5));
    memReq = 1'b0; memReady = 1'b1; exDoJump = 1'b1;
    #1;
    chk("err_ctl", 32'(w_ctl), 32'(C_MS));
    step(); step();
    chk("err_hold_ctl", 32'(w_ctl), 32'(C_MS));
    chk("err_counts", 32'({stallCount, flushCount}), 32'({4'd5, 4'd0}));
    clear_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk("err_rst_ctl", 32'(w_ctl), 32'(C_RST));
    chk("err_rst_memErr", 32'(memErr), 32'(0));
    chk("err_rst_counts", 32'({stallCount, flushCount}), 32'(0));
    step();
    rst_n = 1'b1;
    #1;
    chk("err_rst_run", 32'(w_ctl), 32'(C_IDLE));

    // Jump held in EX under a memory stall resolves on the ready cycle
    do_reset();
    exDoJump = 1'b1; memReq = 1'b1; memReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("bms_ctl%0d", i), 32'(w_ctl), 32'(C_MS));
      step();
    end
    memReady = 1'b1;
    #1;
    chk("bms_ready_ctl", 32'(w_ctl), 32'(C_RD));
    step();
    clear_inputs();
    #1;
    chk("bms_counts", 32'({stallCount, flushCount}), 32'({4'd2, 4'd1}));

    // Counter saturation at all-ones
    do_reset();
    set_load_use();
    for (int i = 0; i < 20; i++) step();
    chk("sat_stallCount", 32'(stallCount), 32'(15));
    clear_inputs();
    exDoJump = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("sat_flushCount", 32'(flushCount), 32'(15));
    chk("sat_stall_hold", 32'(stallCount), 32'(15));
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
